// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: edge/level interrupt aggregator with a 16-bit Avalon-MM register file.
// Define IRQ_CTRL_SYNC_EN to sample irq_in through a 2-flop synchronizer.
module timer_irq_ctrl #(
    parameter int          N_IRQ      = 8,
    parameter logic [15:0] MODE_RESET = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [15:0]      writedata,
    output logic [15:0]      readdata,
    output logic             irq
);
    // Registers are kept 16 bits wide; bits at N_IRQ and above are tied off by valid.
    localparam logic [15:0] VALID = 16'((32'd1 << N_IRQ) - 32'd1);

    logic [15:0] s, p, pending, mask, mode, missed;
    logic [15:0] edg, clr, frc, mclr, edge_next, pend_next, miss_set, pm, rmux;
    logic        wr, act_v;
    logic [3:0]  act_idx;
`ifdef IRQ_CTRL_SYNC_EN
    logic [15:0] s0;
`endif

    assign wr        = chipselect & ~write_n;
    assign edg       = s & ~p;
    assign clr       = (wr && address == 3'd0) ? writedata : '0;
    assign frc       = (wr && address == 3'd3) ? writedata : '0;
    assign mclr      = (wr && address == 3'd6) ? writedata : '0;
    assign edge_next = edg | frc | (pending & ~clr);
    assign pend_next = ((mode & edge_next) | (~mode & s)) & VALID;
    assign miss_set  = mode & edg & pending & ~clr;
    assign pm        = pending & mask;

    always_comb begin
        act_v   = |pm;
        act_idx = '0;
        for (int i = 15; i >= 0; i--)
            if (pm[i]) act_idx = 4'(i);
    end

    always_comb begin
        case (address)
            3'd0:    rmux = pending;
            3'd1:    rmux = mask;
            3'd2:    rmux = mode;
            3'd4:    rmux = {act_v, 11'b0, act_idx};
            3'd5:    rmux = s;
            3'd6:    rmux = missed;
            default: rmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef IRQ_CTRL_SYNC_EN
            s0       <= '0;
`endif
            s        <= '0;
            p        <= '0;
            pending  <= '0;
            mask     <= '0;
            mode     <= MODE_RESET & VALID;
            missed   <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
`ifdef IRQ_CTRL_SYNC_EN
            s0       <= 16'(irq_in);
            s        <= s0;
`else
            s        <= 16'(irq_in);
`endif
            p        <= s;
            pending  <= pend_next;
            mask     <= (wr && address == 3'd1) ? writedata & VALID : mask;
            mode     <= (wr && address == 3'd2) ? writedata & VALID : mode;
            missed   <= ((missed & ~mclr) | miss_set) & VALID;
            irq      <= |pm;
            readdata <= rmux;
        end
    end
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: directed, table-driven bench for timer_irq_ctrl with N_IRQ = 8.
module tb_timer_irq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_in = '0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic [15:0] d;
    logic [7:0]  lvl_exp;
    int          errs = 0;
    int          checks = 0;

    typedef struct {
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[7];
    logic [15:0] rst_exp[8];

    always #5 clk = ~clk;

    timer_irq_ctrl #(.N_IRQ(8), .MODE_RESET(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] v);
        address = a;
        writedata = v;
        chipselect = 1'b1;
        write_n = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] v);
        address = a;
        tick();
        v = readdata;
    endtask

    task automatic pulse(input int b);
        irq_in[b] = 1'b1;
        tick();
        irq_in[b] = 1'b0;
        tick(3);
    endtask

    initial begin
        rst_exp = '{16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[0] = '{3'd1, 16'hFFFF, 3'd1, 16'h00FF};
        tbl[1] = '{3'd2, 16'h1234, 3'd2, 16'h0034};
        tbl[2] = '{3'd2, 16'hFFFF, 3'd2, 16'h00FF};
        tbl[3] = '{3'd1, 16'h0000, 3'd1, 16'h0000};
        tbl[4] = '{3'd5, 16'hFFFF, 3'd5, 16'h0000};
        tbl[5] = '{3'd7, 16'hFFFF, 3'd7, 16'h0000};
        tbl[6] = '{3'd4, 16'hFFFF, 3'd4, 16'h0000};

        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            chk($sformatf("reset_read_a%0d", i), d, rst_exp[i]);
        end
        chk("reset_irq", {15'b0, irq}, 16'h0000);

        for (int i = 0; i < 7; i++) begin
            wr(tbl[i].wa, tbl[i].wd);
            rd(tbl[i].ra, d);
            chk($sformatf("regvec_%0d", i), d, tbl[i].exp);
        end

        // Edge latency on bit 2
        wr(3'd1, 16'h0004);
        address = 3'd0;
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        chk("lat_irq_k1", {15'b0, irq}, 16'h0000);
        tick();
        chk("lat_irq_k2", {15'b0, irq}, 16'h0000);
        chk("lat_pend_k1", readdata, 16'h0000);
        tick();
        chk("lat_irq_k3", {15'b0, irq}, 16'h0001);
        chk("lat_pend_k2", readdata, 16'h0004);
        rd(3'd4, d);
        chk("active_b2", d, 16'h8002);
        wr(3'd0, 16'h0004);
        chk("w1c_irq_1", {15'b0, irq}, 16'h0001);
        tick();
        chk("w1c_irq_2", {15'b0, irq}, 16'h0000);

        // Missed edge and W1C of MISSED
        pulse(2);
        pulse(2);
        rd(3'd6, d);
        chk("missed_set", d, 16'h0004);
        rd(3'd0, d);
        chk("missed_pend", d, 16'h0004);
        wr(3'd6, 16'h0004);
        rd(3'd6, d);
        chk("missed_w1c", d, 16'h0000);

        // W1C in the same cycle as a new edge: set wins, no MISSED
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        wr(3'd0, 16'h0004);
        tick(2);
        rd(3'd0, d);
        chk("setwins_pend", d, 16'h0004);
        rd(3'd6, d);
        chk("setwins_missed", d, 16'h0000);
        wr(3'd0, 16'h00FF);

        // Level mode on bit 0
        wr(3'd2, 16'h00FE);
        wr(3'd1, 16'h0001);
        address = 3'd0;
        lvl_exp = 8'b0111_1100;
        irq_in[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("lvl_irq_%0d", i), {15'b0, irq}, {15'b0, lvl_exp[i-1]});
            chk($sformatf("lvl_pend_%0d", i), readdata, {15'b0, lvl_exp[i-1]});
            if (i == 5) irq_in[0] = 1'b0;
        end
        irq_in[0] = 1'b1;
        tick(3);
        wr(3'd0, 16'h0001);
        tick();
        rd(3'd0, d);
        chk("lvl_w1c_ignored", d, 16'h0001);
        chk("lvl_w1c_irq", {15'b0, irq}, 16'h0001);
        irq_in[0] = 1'b0;
        tick(4);
        chk("lvl_irq_drop", {15'b0, irq}, 16'h0000);

        // Priority and FORCE
        wr(3'd2, 16'h00FF);
        wr(3'd3, 16'h0022);
        wr(3'd1, 16'h0022);
        rd(3'd4, d);
        chk("active_b1", d, 16'h8001);
        wr(3'd1, 16'h0020);
        rd(3'd4, d);
        chk("active_b5", d, 16'h8005);
        wr(3'd1, 16'h0000);
        wr(3'd3, 16'h0080);
        tick(2);
        chk("force_masked_irq", {15'b0, irq}, 16'h0000);
        rd(3'd0, d);
        chk("force_pend", d, 16'h00A2);
        rd(3'd3, d);
        chk("force_reads0", d, 16'h0000);

        // Asynchronous reset mid-operation
        wr(3'd3, 16'h00FF);
        wr(3'd1, 16'h00FF);
        tick(2);
        chk("pre_reset_irq", {15'b0, irq}, 16'h0001);
        rd(3'd0, d);
        chk("pre_reset_pend", d, 16'h00FF);
        #2 reset = 1'b1;
        #1;
        chk("async_irq", {15'b0, irq}, 16'h0000);
        chk("async_readdata", readdata, 16'h0000);
        chk("async_pend", dut.pending, 16'h0000);
        tick();
        reset = 1'b0;
        rd(3'd0, d);
        chk("post_reset_pend", d, 16'h0000);
        rd(3'd1, d);
        chk("post_reset_mask", d, 16'h0000);
        chk("post_reset_irq", {15'b0, irq}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
